// File: rtl/decoder_scan_n_pkg.sv
// Shared types and helpers for the scanning decoder.
// Holds the FSM state enum, mode encodings and the one-cold pattern function.
package decoder_pkg;

   typedef enum logic [1:0] {
      DIS    = 2'd0,
      DIRECT = 2'd1,
      SCAN   = 2'd2
   } dec_state_t;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   // Widest decoder supported by onehot_n; callers keep only the low OUT_W bits.
   localparam int unsigned MAX_SEL_W = 9;
   localparam int unsigned MAX_OUT_W = 2 ** MAX_SEL_W;

   function automatic logic [MAX_OUT_W-1:0] onehot_n(input int unsigned idx);
      return ~(MAX_OUT_W'(1) << idx);
   endfunction

endpackage

// File: rtl/decoder_scan_n_scan_counter.sv
// Dwell counter plus modulo-2**SEL_W index for the scan walk.
// hold freezes everything; load/clear take priority over advancing.
module scan_counter
   import decoder_pkg::*;
#(
   parameter int unsigned SEL_W   = 3,
   parameter int unsigned DWELL_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               load,
   input  logic [SEL_W-1:0]   load_val,
   input  logic               hold,
   input  logic [DWELL_W-1:0] dwell,
   output logic [SEL_W-1:0]   idx,
   output logic [SEL_W-1:0]   idx_nxt,
   output logic               wrap
);

   logic [DWELL_W-1:0] cnt;
   logic [DWELL_W-1:0] cnt_nxt;
   logic               wrap_nxt;

   // Compare against the live dwell so a lowered value advances on the next edge.
   always_comb begin
      idx_nxt  = idx;
      cnt_nxt  = cnt;
      wrap_nxt = 1'b0;
      if (!hold) begin
         if (load || clear) begin
            if (load)  idx_nxt = load_val;
            if (clear) cnt_nxt = '0;
         end else if (cnt >= dwell) begin
            cnt_nxt  = '0;
            idx_nxt  = idx + SEL_W'(1);
            wrap_nxt = (idx == '1);
         end else begin
            cnt_nxt = cnt + DWELL_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx  <= '0;
         cnt  <= '0;
         wrap <= 1'b0;
      end else begin
         idx  <= idx_nxt;
         cnt  <= cnt_nxt;
         wrap <= wrap_nxt;
      end
   end

endmodule

// File: rtl/decoder_scan_n.sv
// Registered SEL_W-to-2**SEL_W decoder with 74138-style enables and a scan mode.
// Outputs are active-low one-cold, all ones while disabled.
module decoder_scan_n
   import decoder_pkg::*;
#(
   parameter int unsigned SEL_W   = 3,
   parameter int unsigned DWELL_W = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  g1,
   input  logic                  g2a_n,
   input  logic                  g2b_n,
   input  logic                  mode,
   input  logic [SEL_W-1:0]      sel_in,
   input  logic [DWELL_W-1:0]    dwell,
   output logic [2**SEL_W-1:0]   dec_out_n,
   output logic [SEL_W-1:0]      scan_idx,
   output logic                  wrap
);

   localparam int unsigned OUT_W = 2 ** SEL_W;

   dec_state_t             state;
   dec_state_t             state_nxt;
   logic                   en;
   logic                   hold;
   logic                   load;
   logic [SEL_W-1:0]       idx_nxt;
   logic [MAX_OUT_W-1:0]   pattern_full;
   logic                   unused_hi;

   // Load happens in DIRECT and on the DIRECT->SCAN edge, so the new index
   // and its output bit appear together on that same edge.
   always_comb begin
      en        = g1 & ~g2a_n & ~g2b_n;
      state_nxt = DIS;
      if (en) state_nxt = (mode == MODE_SCAN) ? SCAN : DIRECT;
      hold         = (state_nxt == DIS);
      load         = (state_nxt == DIRECT) || ((state_nxt == SCAN) && (state == DIRECT));
      pattern_full = onehot_n(32'(idx_nxt));
      unused_hi    = ^pattern_full[MAX_OUT_W-1:OUT_W];
   end

   scan_counter #(
      .SEL_W   (SEL_W),
      .DWELL_W (DWELL_W)
   ) u_scan_counter (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (load),
      .load     (load),
      .load_val (sel_in),
      .hold     (hold),
      .dwell    (dwell),
      .idx      (scan_idx),
      .idx_nxt  (idx_nxt),
      .wrap     (wrap)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= DIS;
         dec_out_n <= '1;
      end else begin
         state     <= state_nxt;
         dec_out_n <= hold ? '1 : pattern_full[OUT_W-1:0];
      end
   end

endmodule

// File: tb/tb_decoder_scan_n.sv
// Scoreboard bench for decoder_scan_n at SEL_W = 3 and SEL_W = 4 sharing stimulus.
// A behavioural model pushes expectations; a monitor pops one per clock edge.
module tb_decoder_scan_n;

   typedef struct {
      logic [15:0] dec;
      int unsigned idx;
      logic        wrap;
   } exp_t;

   localparam int P_DIS = 0, P_DIRECT = 1, P_SCAN = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        g1 = 1'b0, g2a_n = 1'b0, g2b_n = 1'b0, mode = 1'b0;
   logic [3:0]  sel4 = '0;
   logic [3:0]  dwell = '0;
   logic [7:0]  dec3;
   logic [15:0] dec4;
   logic [2:0]  idx3;
   logic [3:0]  idx4;
   logic        wrap3, wrap4;

   int tests = 0;
   int fails = 0;
   exp_t q3[$];
   exp_t q4[$];
   int m_idx[2];
   int m_el[2];
   int m_prev[2];

   always #5 clk = ~clk;

   decoder_scan_n #(.SEL_W(3), .DWELL_W(4)) u3 (
      .clk(clk), .rst_n(rst_n), .g1(g1), .g2a_n(g2a_n), .g2b_n(g2b_n), .mode(mode),
      .sel_in(sel4[2:0]), .dwell(dwell), .dec_out_n(dec3), .scan_idx(idx3), .wrap(wrap3)
   );

   decoder_scan_n #(.SEL_W(4), .DWELL_W(4)) u4 (
      .clk(clk), .rst_n(rst_n), .g1(g1), .g2a_n(g2a_n), .g2b_n(g2b_n), .mode(mode),
      .sel_in(sel4), .dwell(dwell), .dec_out_n(dec4), .scan_idx(idx4), .wrap(wrap4)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_idx[k] = 0; m_el[k] = 0; m_prev[k] = P_DIS;
      end
   endtask

   // Walk the rules: disabled holds, direct follows sel, scan dwells dwell+1 cycles per index.
   task automatic model_step(input int k, output exp_t e);
      int n = (k == 0) ? 8 : 16;
      logic [15:0] mask = (k == 0) ? 16'h00FF : 16'hFFFF;
      bit en = g1 && !g2a_n && !g2b_n;
      e.wrap = 1'b0;
      if (!en) begin
         m_prev[k] = P_DIS;
      end else if (!mode) begin
         m_idx[k] = int'(sel4) % n; m_el[k] = 0; m_prev[k] = P_DIRECT;
      end else begin
         if (m_prev[k] == P_DIRECT) begin
            m_idx[k] = int'(sel4) % n; m_el[k] = 0;
         end else if (m_el[k] >= int'(dwell)) begin
            m_el[k] = 0;
            e.wrap = (m_idx[k] == n - 1);
            m_idx[k] = (m_idx[k] + 1) % n;
         end else begin
            m_el[k]++;
         end
         m_prev[k] = P_SCAN;
      end
      e.idx = m_idx[k];
      e.dec = en ? (mask & ~(16'd1 << m_idx[k])) : mask;
   endtask

   // Called at a falling edge with inputs already set for the coming rising edge.
   task automatic step();
      exp_t e;
      model_step(0, e); q3.push_back(e);
      model_step(1, e); q4.push_back(e);
      @(negedge clk);
   endtask

   task automatic set_en(input logic a, input logic b, input logic c);
      g1 = a; g2a_n = b; g2b_n = c;
   endtask

   initial begin : monitor
      exp_t e;
      int zeros;
      forever begin
         @(posedge clk);
         #1;
         if (q3.size() > 0) begin
            e = q3.pop_front();
            chk("dec3", 32'(dec3), 32'(e.dec));
            chk("idx3", 32'(idx3), e.idx);
            chk("wrap3", 32'(wrap3), 32'(e.wrap));
            zeros = 0;
            for (int i = 0; i < 8; i++) if (!dec3[i]) zeros++;
            chk("onecold3", 32'(zeros <= 1), 32'd1);
         end
         if (q4.size() > 0) begin
            e = q4.pop_front();
            chk("dec4", 32'(dec4), 32'(e.dec));
            chk("idx4", 32'(idx4), e.idx);
            chk("wrap4", 32'(wrap4), 32'(e.wrap));
         end
      end
   end

   initial begin : watchdog
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int guard;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_dec3", 32'(dec3), 32'hFF);
      chk("rst_idx3", 32'(idx3), 32'd0);
      chk("rst_wrap3", 32'(wrap3), 32'd0);
      chk("rst_dec4", 32'(dec4), 32'hFFFF);
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Reset release with each disabling enable combination.
      set_en(0, 0, 0); repeat (2) step();
      set_en(1, 1, 0); repeat (2) step();
      set_en(1, 0, 1); repeat (2) step();

      // Direct sweep across all 16 selects (the 3-bit DUT sees sel mod 8).
      set_en(1, 0, 0); mode = 1'b0;
      for (int s = 0; s < 16; s++) begin
         sel4 = 4'(s); repeat (2) step();
      end

      // Scan from DIRECT at sel 6 with dwell 1, through a wrap.
      sel4 = 4'd6; dwell = 4'd1; step();
      mode = 1'b1;
      repeat (20) step();

      // Disable while index 3 is mid-hold, then resume.
      dwell = 4'd2;
      guard = 0;
      while (!(m_idx[0] == 3 && m_el[0] == 1) && guard < 64) begin step(); guard++; end
      chk("reach_idx3", 32'(guard < 64), 32'd1);
      g1 = 1'b0; repeat (5) step();
      g1 = 1'b1; repeat (8) step();

      // Live dwell change: long hold, counter reaches 8, then dwell drops to 2.
      mode = 1'b0; sel4 = 4'd1; step();
      mode = 1'b1; dwell = 4'd15; repeat (9) step();
      dwell = 4'd2; repeat (12) step();

      // Asynchronous reset between edges while scan index is 5.
      dwell = 4'd0;
      guard = 0;
      while (m_idx[0] != 5 && guard < 64) begin step(); guard++; end
      chk("reach_idx5", 32'(idx3), 32'd5);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("arst_dec3", 32'(dec3), 32'hFF);
      chk("arst_idx3", 32'(idx3), 32'd0);
      chk("arst_wrap3", 32'(wrap3), 32'd0);
      chk("arst_dec4", 32'(dec4), 32'hFFFF);
      model_reset();
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      repeat (4) step();

      // Randomized traffic.
      for (int c = 0; c < 500; c++) begin
         g1    = ($urandom_range(9) != 0);
         g2a_n = ($urandom_range(14) == 0);
         g2b_n = ($urandom_range(14) == 0);
         if ($urandom_range(11) == 0) mode = ~mode;
         if ($urandom_range(5) == 0) sel4 = 4'($urandom);
         if ($urandom_range(15) == 0)
            dwell = ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(2));
         step();
      end

      set_en(0, 0, 0);
      repeat (3) @(negedge clk);
      chk("q3_drained", 32'(q3.size()), 32'd0);
      chk("q4_drained", 32'(q4.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
